// File: rtl/pulse_conditioner.sv
// Synchronizes and deglitches an asynchronous pulse line, emitting a filtered level plus edge strobes.
// Define PULSE_COND_GLITCH_CNT_EN to add the saturating glitch counter (i_glitch_clr / o_glitch_cnt).
module pulse_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pulse_raw,
    input  logic              i_en,
    input  logic [FILT_W-1:0] i_filt_len,
`ifdef PULSE_COND_GLITCH_CNT_EN
    input  logic              i_glitch_clr,
    output logic [15:0]       o_glitch_cnt,
`endif
    output logic              o_pulse,
    output logic              o_rise,
    output logic              o_fall
);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    localparam logic [FILT_W-1:0] CNT_ZERO = {FILT_W{1'b0}};
    localparam logic [FILT_W-1:0] CNT_ONE  = {{(FILT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q;
    logic [FILT_W-1:0]      cnt_q;
    logic [FILT_W-1:0]      nl_q;
    logic                   pulse_q;
    logic                   rise_q;
    logic                   fall_q;

    logic                   sync_s;
    logic [FILT_W-1:0]      len_eff_s;
    logic                   differ_s;

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign len_eff_s = (i_filt_len == CNT_ZERO) ? CNT_ONE : i_filt_len;
    assign differ_s  = sync_s ^ pulse_q;

    // Metastability synchronizer on the raw line; keeps running while the filter is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pulse_raw};
        end
    end

    // Stability FSM: a level change is accepted only after it persists for the latched length.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= CNT_ZERO;
            nl_q    <= CNT_ONE;
            pulse_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!i_en) begin
                state_q <= ST_STABLE;
                cnt_q   <= CNT_ZERO;
            end else begin
                case (state_q)
                    ST_STABLE: begin
                        cnt_q <= CNT_ZERO;
                        if (differ_s) begin
                            state_q <= ST_CHECK;
                            nl_q    <= len_eff_s;
                        end
                    end
                    ST_CHECK: begin
                        if (!differ_s) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= CNT_ZERO;
                        end else if (cnt_q == (nl_q - CNT_ONE)) begin
                            // Strobes are registered alongside the level so they align with o_pulse.
                            pulse_q <= sync_s;
                            rise_q  <= sync_s;
                            fall_q  <= ~sync_s;
                            cnt_q   <= CNT_ZERO;
                            state_q <= ST_STABLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_STABLE;
                        cnt_q   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

`ifdef PULSE_COND_GLITCH_CNT_EN
    logic        abort_s;
    logic [15:0] glitch_q;

    assign abort_s = i_en & (state_q == ST_CHECK) & ~differ_s;

    // Saturating count of qualification windows that collapsed before acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            glitch_q <= 16'h0000;
        end else if (i_glitch_clr) begin
            glitch_q <= 16'h0000;
        end else if (abort_s && (glitch_q != 16'hFFFF)) begin
            glitch_q <= glitch_q + 16'h0001;
        end else begin
            glitch_q <= glitch_q;
        end
    end

    assign o_glitch_cnt = glitch_q;
`endif

    assign o_pulse = pulse_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Self-checking bench for pulse_conditioner: directed scenarios plus randomized traffic
// compared cycle by cycle against a run-length reference model.
module tb_pulse_conditioner;

    localparam int SYNC = 2;
    localparam int FW   = 8;

    logic          i_clk       = 1'b0;
    logic          i_rst_n     = 1'b0;
    logic          i_pulse_raw = 1'b0;
    logic          i_en        = 1'b0;
    logic [FW-1:0] i_filt_len  = 8'd4;
    logic          o_pulse, o_rise, o_fall;
`ifdef PULSE_COND_GLITCH_CNT_EN
    logic          i_glitch_clr = 1'b0;
    logic [15:0]   o_glitch_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    pulse_conditioner #(.SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_pulse_raw (i_pulse_raw),
        .i_en        (i_en),
        .i_filt_len  (i_filt_len),
`ifdef PULSE_COND_GLITCH_CNT_EN
        .i_glitch_clr(i_glitch_clr),
        .o_glitch_cnt(o_glitch_cnt),
`endif
        .o_pulse     (o_pulse),
        .o_rise      (o_rise),
        .o_fall      (o_fall)
    );

    // Reference model: the line seen by the filter is the raw input delayed SYNC samples;
    // a new level is taken once it has differed from the output on Nl+1 consecutive enabled samples.
    logic [SYNC-1:0] m_hist   = '0;
    logic            m_p      = 1'b0;
    logic            m_rise   = 1'b0;
    logic            m_fall   = 1'b0;
    int              m_run    = 0;
    int              m_nl     = 1;
    logic [15:0]     m_glitch = 16'd0;

    always @(posedge i_clk or negedge i_rst_n) begin : p_model
        logic s_now;
        logic clr_now;
        if (!i_rst_n) begin
            m_hist <= '0; m_p <= 1'b0; m_rise <= 1'b0; m_fall <= 1'b0;
            m_run <= 0; m_nl <= 1; m_glitch <= 16'd0;
        end else begin
            s_now = m_hist[SYNC-1];
`ifdef PULSE_COND_GLITCH_CNT_EN
            clr_now = i_glitch_clr;
`else
            clr_now = 1'b0;
`endif
            m_hist <= {m_hist[SYNC-2:0], i_pulse_raw};
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (clr_now) m_glitch <= 16'd0;
            if (!i_en) begin
                m_run <= 0;
            end else if (s_now != m_p) begin
                if (m_run == 0) begin
                    m_nl  <= (i_filt_len == 8'd0) ? 1 : int'(i_filt_len);
                    m_run <= 1;
                end else if (m_run == m_nl) begin
                    m_p    <= s_now;
                    m_rise <= s_now;
                    m_fall <= ~s_now;
                    m_run  <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                if (m_run > 0 && !clr_now && m_glitch != 16'hFFFF) m_glitch <= m_glitch + 16'd1;
                m_run <= 0;
            end
        end
    end

    task automatic test_reset();
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            if ({o_pulse, o_rise, o_fall} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got pulse/rise/fall=%b%b%b expected 000", c, o_pulse, o_rise, o_fall);
            end
            n_tests++;
`ifdef PULSE_COND_GLITCH_CNT_EN
            if (o_glitch_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_glitch cyc=%0d got %0d expected 0", c, o_glitch_cnt);
            end
            n_tests++;
`endif
            i_pulse_raw = 1'($urandom_range(0, 1));
        end
        i_pulse_raw = 1'b0;
        @(negedge i_clk);
        i_rst_n    = 1'b1;
        i_en       = 1'b1;
        i_filt_len = 8'd4;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if ({o_pulse, o_rise, o_fall} !== {m_p, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d got %b%b%b expected %b%b%b", c, o_pulse, o_rise, o_fall, m_p, m_rise, m_fall);
            end
            n_tests++;
        end
    endtask

    task automatic test_clean_pulses();
        int rises = 0, falls = 0, bad_run = 0, bad_lat = 0, hi_len = 0, c_rise = 0;
        logic prev_p = 1'b0;
        i_filt_len = 8'd4;
        i_en       = 1'b1;
        for (int c = 0; c < 4020; c++) begin
            @(negedge i_clk);
            if ({o_pulse, o_rise, o_fall} !== {m_p, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL clean_model cyc=%0d got %b%b%b expected %b%b%b", c, o_pulse, o_rise, o_fall, m_p, m_rise, m_fall);
            end
            n_tests++;
            if (o_rise) begin
                rises++;
                if (c - c_rise < 6 || c - c_rise > 7) bad_lat++;
            end
            if (o_fall) falls++;
            if (o_pulse) hi_len++;
            if (prev_p && !o_pulse) begin
                if (hi_len != 30) bad_run++;
                hi_len = 0;
            end
            prev_p = o_pulse;
            if (c < 4000 && (c % 80) == 0) c_rise = c;
            i_pulse_raw = (c < 4000) && ((c % 80) < 30);
        end
        if (rises !== 50) begin n_fail++; $display("FAIL clean_rises got %0d expected 50", rises); end
        n_tests++;
        if (falls !== 50) begin n_fail++; $display("FAIL clean_falls got %0d expected 50", falls); end
        n_tests++;
        if (bad_run !== 0) begin n_fail++; $display("FAIL clean_high_len got %0d runs not 30 cycles expected 0", bad_run); end
        n_tests++;
        if (bad_lat !== 0) begin n_fail++; $display("FAIL clean_latency got %0d rises outside 6-7 cycles expected 0", bad_lat); end
        n_tests++;
    endtask

    task automatic test_glitch();
        int strobes = 0, highs = 0;
        i_filt_len = 8'd4;
        for (int c = 0; c < 150; c++) begin
            @(negedge i_clk);
            if ({o_pulse, o_rise, o_fall} !== {m_p, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL glitch_model cyc=%0d got %b%b%b expected %b%b%b", c, o_pulse, o_rise, o_fall, m_p, m_rise, m_fall);
            end
            n_tests++;
            strobes += int'(o_rise) + int'(o_fall);
            highs   += int'(o_pulse);
`ifdef PULSE_COND_GLITCH_CNT_EN
            i_glitch_clr = (c == 0);
`endif
            i_pulse_raw = (c < 130) && ((c % 13) < 3);
        end
        if (strobes !== 0 || highs !== 0) begin
            n_fail++;
            $display("FAIL glitch_reject got strobes=%0d high_cycles=%0d expected 0 0", strobes, highs);
        end
        n_tests++;
`ifdef PULSE_COND_GLITCH_CNT_EN
        if (o_glitch_cnt !== 16'd10) begin n_fail++; $display("FAIL glitch_count got %0d expected 10", o_glitch_cnt); end
        n_tests++;
`endif
    endtask

    task automatic test_disable();
        int strobes = 0, changes = 0;
        i_en = 1'b0;
        for (int c = 0; c < 760; c++) begin
            @(negedge i_clk);
            if (o_pulse !== 1'b0) changes++;
            strobes += int'(o_rise) + int'(o_fall);
            i_pulse_raw = (c < 750) && ((c % 50) < 30);
        end
        if (changes !== 0) begin n_fail++; $display("FAIL disable_level got %0d cycles high expected 0", changes); end
        n_tests++;
        if (strobes !== 0) begin n_fail++; $display("FAIL disable_strobes got %0d expected 0", strobes); end
        n_tests++;
`ifdef PULSE_COND_GLITCH_CNT_EN
        if (o_glitch_cnt !== 16'd10) begin n_fail++; $display("FAIL disable_glitch got %0d expected 10", o_glitch_cnt); end
        n_tests++;
`endif
        i_en = 1'b1;
    endtask

    task automatic test_boundaries();
        int rises, falls, lat, strobes;
        // Length 0 must behave as length 1: shortest pulse is accepted with the 1-length latency.
        rises = 0; falls = 0; lat = -1;
        i_filt_len = 8'd0;
        for (int c = 0; c < 30; c++) begin
            @(negedge i_clk);
            if ({o_pulse, o_rise, o_fall} !== {m_p, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL len0_model cyc=%0d got %b%b%b expected %b%b%b", c, o_pulse, o_rise, o_fall, m_p, m_rise, m_fall);
            end
            n_tests++;
            if (o_rise) begin rises++; lat = c; end
            if (o_fall) falls++;
            i_pulse_raw = (c < 2);
        end
        if (rises !== 1 || falls !== 1 || lat !== 4) begin
            n_fail++;
            $display("FAIL len0_accept got rises=%0d falls=%0d lat=%0d expected 1 1 4", rises, falls, lat);
        end
        n_tests++;
        // Length raised to 200 mid-qualification: the latched 4 still applies.
        rises = 0; lat = -1;
        i_filt_len = 8'd4;
        for (int c = 0; c < 60; c++) begin
            @(negedge i_clk);
            if ({o_pulse, o_rise, o_fall} !== {m_p, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL lenchg_model cyc=%0d got %b%b%b expected %b%b%b", c, o_pulse, o_rise, o_fall, m_p, m_rise, m_fall);
            end
            n_tests++;
            if (o_rise) begin rises++; lat = c; end
            if (c == 3)  i_filt_len = 8'd200;
            if (c == 20) i_filt_len = 8'd4;
            i_pulse_raw = (c < 40);
        end
        if (rises !== 1 || lat !== 7) begin
            n_fail++;
            $display("FAIL lenchg_latency got rises=%0d lat=%0d expected 1 7", rises, lat);
        end
        n_tests++;
        // Reset during qualification discards the pending rise.
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if ({o_pulse, o_rise, o_fall} !== {m_p, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL rstmid_model cyc=%0d got %b%b%b expected %b%b%b", c, o_pulse, o_rise, o_fall, m_p, m_rise, m_fall);
            end
            n_tests++;
            if (c > 7) strobes += int'(o_rise) + int'(o_fall);
            if (c == 4) i_rst_n = 1'b0;
            if (c == 7) i_rst_n = 1'b1;
            i_pulse_raw = (c < 4);
        end
        if (strobes !== 0) begin n_fail++; $display("FAIL rstmid_strobes got %0d expected 0", strobes); end
        n_tests++;
    endtask

    task automatic test_random();
        int seg_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge i_clk);
            if ({o_pulse, o_rise, o_fall} !== {m_p, m_rise, m_fall}) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got %b%b%b expected %b%b%b", c, o_pulse, o_rise, o_fall, m_p, m_rise, m_fall);
            end
            n_tests++;
`ifdef PULSE_COND_GLITCH_CNT_EN
            if (o_glitch_cnt !== m_glitch) begin
                n_fail++;
                $display("FAIL random_glitch cyc=%0d got %0d expected %0d", c, o_glitch_cnt, m_glitch);
            end
            n_tests++;
            i_glitch_clr = ($urandom_range(0, 49) == 0);
`endif
            if (seg_left == 0) begin
                i_pulse_raw = ~i_pulse_raw;
                seg_left    = $urandom_range(1, 12);
                if ($urandom_range(0, 3) == 0) i_en = ($urandom_range(0, 9) != 0);
            end
            seg_left--;
            if ($urandom_range(0, 15) == 0) i_filt_len = 8'($urandom_range(0, 6));
        end
    endtask

    initial begin
        test_reset();
        test_clean_pulses();
        test_glitch();
        test_disable();
        test_boundaries();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
